// File: rtl/exp_align_pipe.sv
// rtl/exp_align_pipe.sv - two-stage exponent compare and mantissa align pipeline for FP add/sub
// Define EXP_ALIGN_STICKY_EN to build the sticky-bit reduction; otherwise out_sticky is tied low.
module exp_align_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [EXP_W-1:0]   exp1,
    input  logic [EXP_W-1:0]   exp2,
    input  logic [MAN_W-1:0]   man1,
    input  logic [MAN_W-1:0]   man2,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W-1:0]   out_exp,
    output logic [EXP_W-1:0]   out_diff,
    output logic               out_swap,
    output logic               out_eq,
    output logic [MAN_W-1:0]   out_man_big,
    output logic [MAN_W+1:0]   out_man_small,
    output logic               out_sticky
);
    localparam int EXT_W = MAN_W + 2;

    logic               s1_valid, s2_valid;
    logic               s1_adv, s2_adv;

    logic [EXP_W-1:0]   s1_exp, s1_diff;
    logic               s1_swap, s1_eq;
    logic [MAN_W-1:0]   s1_man_big, s1_man_small;

    logic [EXP_W-1:0]   s2_exp, s2_diff;
    logic               s2_swap, s2_eq;
    logic [MAN_W-1:0]   s2_man_big;
    logic [EXT_W-1:0]   s2_man_small;

    logic [EXP_W:0]     c_sub;
    logic               c_swap, c_eq;
    logic [EXP_W-1:0]   c_diff, c_exp;
    logic [MAN_W-1:0]   c_big, c_small;

    logic [EXT_W-1:0]   ext, aligned;
    logic               sat;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Stage 1: the borrow of the widened subtraction picks the larger exponent.
    always_comb begin
        c_sub   = {1'b0, exp1} - {1'b0, exp2};
        c_swap  = c_sub[EXP_W];
        c_diff  = c_swap ? (exp2 - exp1) : c_sub[EXP_W-1:0];
        c_eq    = (c_sub == '0);
        c_exp   = c_swap ? exp2 : exp1;
        c_big   = c_swap ? man2 : man1;
        c_small = c_swap ? man1 : man2;
    end

    // Stage 2: shifts of EXT_W or more would drop everything, so they saturate to zero.
    always_comb begin
        ext     = {s1_man_small, 2'b00};
        sat     = 32'(s1_diff) >= EXT_W;
        aligned = sat ? '0 : (ext >> s1_diff);
    end

`ifdef EXP_ALIGN_STICKY_EN
    logic [EXT_W-1:0] lost;
    logic             c_sticky;
    logic             s2_sticky;

    always_comb begin
        lost     = ext & ~({EXT_W{1'b1}} << s1_diff);
        c_sticky = sat ? |s1_man_small : |lost;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s2_sticky <= 1'b0;
        end else if (s2_adv && s1_valid) begin
            s2_sticky <= c_sticky;
        end
    end

    assign out_sticky = s2_sticky;
`else
    assign out_sticky = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid     <= 1'b0;
            s1_exp       <= '0;
            s1_diff      <= '0;
            s1_swap      <= 1'b0;
            s1_eq        <= 1'b0;
            s1_man_big   <= '0;
            s1_man_small <= '0;
            s2_valid     <= 1'b0;
            s2_exp       <= '0;
            s2_diff      <= '0;
            s2_swap      <= 1'b0;
            s2_eq        <= 1'b0;
            s2_man_big   <= '0;
            s2_man_small <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_exp       <= c_exp;
                    s1_diff      <= c_diff;
                    s1_swap      <= c_swap;
                    s1_eq        <= c_eq;
                    s1_man_big   <= c_big;
                    s1_man_small <= c_small;
                end
            end
            // Output registers only change when the consumer has taken the current result.
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_exp       <= s1_exp;
                    s2_diff      <= s1_diff;
                    s2_swap      <= s1_swap;
                    s2_eq        <= s1_eq;
                    s2_man_big   <= s1_man_big;
                    s2_man_small <= aligned;
                end
            end
        end
    end

    assign out_valid     = s2_valid;
    assign out_exp       = s2_exp;
    assign out_diff      = s2_diff;
    assign out_swap      = s2_swap;
    assign out_eq        = s2_eq;
    assign out_man_big   = s2_man_big;
    assign out_man_small = s2_man_small;

endmodule

// File: tb/tb_exp_align_pipe.sv
// tb/tb_exp_align_pipe.sv - directed table-driven bench for exp_align_pipe
module tb_exp_align_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid, in_ready;
    logic [7:0]  exp1, exp2;
    logic [23:0] man1, man2;
    logic        out_valid, out_ready;
    logic [7:0]  out_exp, out_diff;
    logic        out_swap, out_eq;
    logic [23:0] out_man_big;
    logic [25:0] out_man_small;
    logic        out_sticky;

    exp_align_pipe #(.EXP_W(8), .MAN_W(24)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .exp1         (exp1),
        .exp2         (exp2),
        .man1         (man1),
        .man2         (man2),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_exp      (out_exp),
        .out_diff     (out_diff),
        .out_swap     (out_swap),
        .out_eq       (out_eq),
        .out_man_big  (out_man_big),
        .out_man_small(out_man_small),
        .out_sticky   (out_sticky)
    );

    always #5 CLK = ~CLK;

`ifdef EXP_ALIGN_STICKY_EN
    localparam logic STICKY_ON = 1'b1;
`else
    localparam logic STICKY_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0]  e1, e2;
        logic [23:0] m1, m2;
        logic [7:0]  x_exp, x_diff;
        logic        x_swap, x_eq;
        logic [23:0] x_big;
        logic [25:0] x_small;
        logic        x_sticky;
    } vec_t;

    localparam int NV = 9;
    vec_t tv [NV];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input vec_t v, input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(1'b1));
        chk({tag, ".exp"}, 32'(out_exp), 32'(v.x_exp));
        chk({tag, ".diff"}, 32'(out_diff), 32'(v.x_diff));
        chk({tag, ".swap"}, 32'(out_swap), 32'(v.x_swap));
        chk({tag, ".eq"}, 32'(out_eq), 32'(v.x_eq));
        chk({tag, ".big"}, 32'(out_man_big), 32'(v.x_big));
        chk({tag, ".small"}, 32'(out_man_small), 32'(v.x_small));
        chk({tag, ".sticky"}, 32'(out_sticky), 32'(v.x_sticky & STICKY_ON));
    endtask

    task automatic drive(input vec_t v);
        exp1 = v.e1; exp2 = v.e2; man1 = v.m1; man2 = v.m2;
        in_valid = 1'b1;
    endtask

    int          idx, nout, stale;
    logic        acc, drn, prev_stall;
    logic [7:0]  snap_exp, snap_diff;
    logic [23:0] snap_big;
    logic [25:0] snap_small;

    initial begin
        //           e1     e2     m1          m2          exp    diff   sw    eq    big         small           st
        tv[0] = '{8'h80, 8'h7E, 24'h800000, 24'hC00000, 8'h80, 8'h02, 1'b0, 1'b0, 24'h800000, 26'h0C00000, 1'b0};
        tv[1] = '{8'h10, 8'h20, 24'hFFFFFF, 24'h800000, 8'h20, 8'h10, 1'b1, 1'b0, 24'h800000, 26'h00003FF, 1'b1};
        tv[2] = '{8'hFF, 8'h00, 24'hABCDEF, 24'h000001, 8'hFF, 8'hFF, 1'b0, 1'b0, 24'hABCDEF, 26'h0000000, 1'b1};
        tv[3] = '{8'h55, 8'h55, 24'h123456, 24'hABCDEF, 8'h55, 8'h00, 1'b0, 1'b1, 24'h123456, 26'h2AF37BC, 1'b0};
        tv[4] = '{8'h19, 8'h00, 24'h000000, 24'hFFFFFF, 8'h19, 8'h19, 1'b0, 1'b0, 24'h000000, 26'h0000001, 1'b1};
        tv[5] = '{8'h1A, 8'h00, 24'h400000, 24'h800000, 8'h1A, 8'h1A, 1'b0, 1'b0, 24'h400000, 26'h0000000, 1'b1};
        tv[6] = '{8'h41, 8'h40, 24'hF00000, 24'h000003, 8'h41, 8'h01, 1'b0, 1'b0, 24'hF00000, 26'h0000006, 1'b0};
        tv[7] = '{8'h00, 8'h03, 24'h000007, 24'h800000, 8'h03, 8'h03, 1'b1, 1'b0, 24'h800000, 26'h0000003, 1'b1};
        tv[8] = '{8'hFF, 8'h00, 24'h800000, 24'h000000, 8'hFF, 8'hFF, 1'b0, 1'b0, 24'h800000, 26'h0000000, 1'b0};

        RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        exp1 = '0; exp2 = '0; man1 = '0; man2 = '0;
        #12;
        @(posedge CLK); #1 RST = 1'b0;
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'(1'b0));
        chk("rst.in_ready", 32'(in_ready), 32'(1'b1));
        chk("rst.out_exp", 32'(out_exp), 32'(8'h00));
        chk("rst.out_diff", 32'(out_diff), 32'(8'h00));
        chk("rst.out_swap", 32'(out_swap), 32'(1'b0));
        chk("rst.out_eq", 32'(out_eq), 32'(1'b0));
        chk("rst.out_man_big", 32'(out_man_big), 32'(24'h0));
        chk("rst.out_man_small", 32'(out_man_small), 32'(26'h0));
        chk("rst.out_sticky", 32'(out_sticky), 32'(1'b0));

        // One operand pair at a time with an exact two-edge latency check.
        @(posedge CLK); #1;
        for (int i = 0; i < NV; i++) begin
            drive(tv[i]);
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(1'b1));
            @(posedge CLK); #1 in_valid = 1'b0;
            chk($sformatf("v%0d.lat1_valid", i), 32'(out_valid), 32'(1'b0));
            @(posedge CLK); #1;
            check_out(tv[i], $sformatf("v%0d", i));
        end
        @(posedge CLK); #1;

        // Backpressure: four back-to-back pairs, consumer stalled for four cycles.
        idx = 0; nout = 0; prev_stall = 1'b0;
        snap_exp = '0; snap_diff = '0; snap_big = '0; snap_small = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = (cyc >= 4);
            if (idx < 4) drive(tv[idx]);
            else in_valid = 1'b0;
            #1;
            if (cyc == 2 || cyc == 3)
                chk($sformatf("bp.in_ready_low_c%0d", cyc), 32'(in_ready), 32'(1'b0));
            if (prev_stall) begin
                chk($sformatf("bp.hold_valid_c%0d", cyc), 32'(out_valid), 32'(1'b1));
                chk($sformatf("bp.hold_exp_c%0d", cyc), 32'(out_exp), 32'(snap_exp));
                chk($sformatf("bp.hold_diff_c%0d", cyc), 32'(out_diff), 32'(snap_diff));
                chk($sformatf("bp.hold_big_c%0d", cyc), 32'(out_man_big), 32'(snap_big));
                chk($sformatf("bp.hold_small_c%0d", cyc), 32'(out_man_small), 32'(snap_small));
            end
            acc = in_valid & in_ready;
            drn = out_valid & out_ready;
            if (drn) begin
                if (nout < 4) check_out(tv[nout], $sformatf("bp.out%0d", nout));
                nout++;
            end
            prev_stall = out_valid & ~out_ready;
            snap_exp = out_exp; snap_diff = out_diff;
            snap_big = out_man_big; snap_small = out_man_small;
            if (cyc == 2) chk("bp.accepts_before_stall", 32'(idx), 32'(2));
            @(posedge CLK); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp.accepted", 32'(idx), 32'(4));
        chk("bp.drained", 32'(nout), 32'(4));

        // Reset with both stages full must discard everything in flight.
        out_ready = 1'b0;
        drive(tv[0]);
        @(posedge CLK); #1 drive(tv[1]);
        @(posedge CLK); #1 in_valid = 1'b0;
        chk("mid.pre_out_valid", 32'(out_valid), 32'(1'b1));
        chk("mid.pre_in_ready", 32'(in_ready), 32'(1'b0));
        #2 RST = 1'b1;
        #1;
        chk("mid.out_valid", 32'(out_valid), 32'(1'b0));
        chk("mid.in_ready", 32'(in_ready), 32'(1'b1));
        chk("mid.out_exp", 32'(out_exp), 32'(8'h00));
        chk("mid.out_man_big", 32'(out_man_big), 32'(24'h0));
        chk("mid.out_man_small", 32'(out_man_small), 32'(26'h0));
        @(posedge CLK); #1 RST = 1'b0; out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(posedge CLK); #1;
            if (out_valid) stale++;
        end
        chk("mid.no_stale", 32'(stale), 32'(0));
        drive(tv[2]);
        @(posedge CLK); #1 in_valid = 1'b0;
        @(posedge CLK); #1;
        check_out(tv[2], "mid.after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
